// File: rtl/permutation_sequencer.sv
// Iterative Ascon permutation: one round p_L(p_S(p_C(x))) per clock on a 320-bit state register.
// State packing: x0 = [319:256], x1 = [255:192], x2 = [191:128], x3 = [127:64], x4 = [63:0].
module permutation_sequencer #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] FIRST_ROUND_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] FIRST_ROUND_B = 4'(12 - ROUNDS_B);

  // S-box indexed by {x0, x1, x2, x3, x4} of one bit column, x0 as MSB.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e         fsm_q;
  logic [63:0]  cx [5];
  logic [63:0]  sx [5];
  logic [63:0]  lx [5];
  logic [4:0]   col;
  logic [7:0]   rc;
  logic [319:0] round_out;
  logic [3:0]   first_round;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  always_comb begin
    col = '0;
    rc  = {~round_o, round_o};
    for (int i = 0; i < 5; i++) begin
      cx[i] = state_o[319 - 64*i -: 64];
      sx[i] = '0;
    end
    cx[2] = state_o[191:128] ^ {56'd0, rc};
    for (int b = 0; b < 64; b++) begin
      col = SBOX[{cx[0][b], cx[1][b], cx[2][b], cx[3][b], cx[4][b]}];
      for (int i = 0; i < 5; i++) begin
        sx[i][b] = col[4 - i];
      end
    end
    lx[0] = sx[0] ^ ror64(sx[0], 19) ^ ror64(sx[0], 28);
    lx[1] = sx[1] ^ ror64(sx[1], 61) ^ ror64(sx[1], 39);
    lx[2] = sx[2] ^ ror64(sx[2], 1)  ^ ror64(sx[2], 6);
    lx[3] = sx[3] ^ ror64(sx[3], 10) ^ ror64(sx[3], 17);
    lx[4] = sx[4] ^ ror64(sx[4], 7)  ^ ror64(sx[4], 41);
    round_out = {lx[0], lx[1], lx[2], lx[3], lx[4]};
  end

  assign first_round = mode_i ? FIRST_ROUND_B : FIRST_ROUND_A;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= StIdle;
      state_o <= '0;
      round_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (fsm_q)
        StIdle, StDone: begin
          done_o <= 1'b0;
          if (start_i) begin
            fsm_q   <= StRun;
            state_o <= state_i;
            round_o <= first_round;
            busy_o  <= 1'b1;
          end else begin
            fsm_q  <= StIdle;
            busy_o <= 1'b0;
          end
        end
        StRun: begin
          state_o <= round_out;
          // Last round keeps round_o at 11 until the next start reloads it.
          if (round_o == 4'd11) begin
            fsm_q  <= StDone;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            round_o <= round_o + 4'd1;
          end
        end
        default: begin
          fsm_q  <= StIdle;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_permutation_sequencer.sv
// Directed bench for permutation_sequencer; expected states come from a bit-sliced Ascon model.
module tb_permutation_sequencer;

  localparam int unsigned RA = 12;
  localparam int unsigned RB = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [319:0] state_in = '0;
  logic [319:0] state_out;
  logic [3:0]   round;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  permutation_sequencer #(
    .ROUNDS_A(RA),
    .ROUNDS_B(RB)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .start_i(start),
    .mode_i (mode),
    .state_i(state_in),
    .state_o(state_out),
    .round_o(round),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  always @(posedge done) done_seen++;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference written from the boolean S-box equations and slice-based rotations.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 12 - n; r < 12; r++) begin
      x2 = x2 ^ 64'((15 - r) * 16 + r);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
      x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
      x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
      x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
      x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Called on a falling edge; leaves in the DONE cycle when chain is set, else one cycle later.
  task automatic run_perm(input string tag, input logic m, input logic [319:0] s, input bit chain);
    int n;
    logic [319:0] exp;
    n = m ? RB : RA;
    exp = ref_perm(s, n);
    start = 1'b1; mode = m; state_in = s;
    @(negedge clk);
    start = 1'b0; mode = ~m; state_in = ~s;
    for (int k = 0; k < n; k++) begin
      chk({tag, ":round"}, round, 320'(12 - n + k));
      chk({tag, ":busy"}, busy, 320'(1));
      chk({tag, ":done_low"}, done, 320'(0));
      @(negedge clk);
    end
    chk({tag, ":done"}, done, 320'(1));
    chk({tag, ":busy_end"}, busy, 320'(0));
    chk({tag, ":state"}, state_out, exp);
    chk({tag, ":round_end"}, round, 320'(11));
    if (!chain) begin
      @(negedge clk);
      chk({tag, ":done_pulse"}, done, 320'(0));
      chk({tag, ":state_hold"}, state_out, exp);
      chk({tag, ":round_hold"}, round, 320'(11));
    end
  endtask

  initial begin
    logic [319:0] s, exp;
    int d0;

    // Reset
    #1 rst = 1'b1;
    #1;
    chk("rst_state", state_out, '0);
    chk("rst_round", round, '0);
    chk("rst_busy", busy, '0);
    chk("rst_done", done, '0);
    #9 rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, '0);
    chk("idle_done", done, '0);

    // p12 on the Ascon-128 initial state, then p6
    run_perm("p12_iv", 1'b0, {64'h80400c0600000000, 256'd0}, 1'b0);
    run_perm("p6", 1'b1, {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f,
                          64'hffffffffffffffff, 64'h0000000000000001}, 1'b0);

    // start held through the whole run; state_i scrambled each cycle
    d0 = done_seen;
    s = rand320();
    exp = ref_perm(s, RA);
    start = 1'b1; mode = 1'b0; state_in = s;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      state_in = rand320();
      mode = k[0];
    end
    start = 1'b0;
    chk("hold_done", done, 320'(1));
    chk("hold_state", state_out, exp);
    repeat (8) @(negedge clk);
    chk("hold_one_done", 320'(done_seen - d0), 320'(1));
    chk("hold_idle", busy, '0);
    chk("hold_state_kept", state_out, exp);

    // Back-to-back runs started in the DONE cycle
    d0 = done_seen;
    run_perm("b2b_a", 1'b0, rand320(), 1'b1);
    run_perm("b2b_b", 1'b1, rand320(), 1'b1);
    run_perm("b2b_c", 1'b0, rand320(), 1'b0);
    chk("b2b_done_count", 320'(done_seen - d0), 320'(3));

    // Asynchronous reset between edges at round 5
    d0 = done_seen;
    start = 1'b1; mode = 1'b0; state_in = rand320();
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_round5", round, 320'(5));
    #2 rst = 1'b1;
    #1;
    chk("abort_state", state_out, '0);
    chk("abort_round", round, '0);
    chk("abort_busy", busy, '0);
    chk("abort_done", done, '0);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", 320'(done_seen - d0), 320'(0));
    chk("abort_idle", busy, '0);
    run_perm("post_reset", 1'b0, rand320(), 1'b0);

    // Random states, mixed modes, some chained
    for (int i = 0; i < 500; i++) begin
      run_perm("rand", 1'($urandom_range(0, 1)), rand320(), (i % 4 == 1) && (i < 499));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
